// File: rtl/modulo_entrada_jogada.sv
// Input front-end for the naval-battle board: synchronises and debounces the raw controls and issues one
// validated line/column command per confirm press. Optional macro SHOT_HISTORY_EN rejects repeated attack shots.
module modulo_entrada_jogada #(
    parameter int DEB_CYCLES = 500000,
    parameter int DEB_W      = 20,
    parameter int N_LINES    = 7,
    parameter int N_COLS     = 5
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [1:0] hh1,
    input  logic [5:0] hh2,
    input  logic       button_clk,
    input  logic       button_clr,
    input  logic       cmd_ready,
    output logic       cmd_valid,
    output logic [2:0] cmd_line,
    output logic [2:0] cmd_col,
    output logic [1:0] cmd_mode,
    output logic       clr_pulse,
    output logic       err_coord,
    output logic [1:0] fsm_state
);
    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        PRESENT  = 2'b01,
        WAIT_REL = 2'b10
    } state_t;

    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
    localparam logic [3:0]       LINES_L  = 4'(N_LINES);
    localparam logic [3:0]       COLS_L   = 4'(N_COLS);

    logic [1:0] hh1_s1_q, hh1_s2_q;
    logic [5:0] hh2_s1_q, hh2_s2_q;
    logic [1:0] btn_s1_q, btn_s2_q;   // {clear, confirm}, still active-low here

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            hh1_s1_q <= '0;
            hh1_s2_q <= '0;
            hh2_s1_q <= '0;
            hh2_s2_q <= '0;
            btn_s1_q <= 2'b11;
            btn_s2_q <= 2'b11;
        end else begin
            hh1_s1_q <= hh1;
            hh1_s2_q <= hh1_s1_q;
            hh2_s1_q <= hh2;
            hh2_s2_q <= hh2_s1_q;
            btn_s1_q <= {button_clr, button_clk};
            btn_s2_q <= btn_s1_q;
        end
    end

    logic [1:0] btn_pressed;
    logic [1:0] btn_rise;
    assign btn_pressed = ~btn_s2_q;

    // Level flips only after it has disagreed with the synced input for DEB_CYCLES edges in a row
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_deb
            logic             level_q;
            logic [DEB_W-1:0] cnt_q;
            logic             settle;

            assign settle = (btn_pressed[gi] != level_q) && (cnt_q == DEB_LAST);

            always_ff @(posedge clk or posedge clr) begin
                if (clr) begin
                    level_q <= 1'b0;
                    cnt_q   <= '0;
                end else if (btn_pressed[gi] == level_q) begin
                    cnt_q <= '0;
                end else if (settle) begin
                    level_q <= btn_pressed[gi];
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end

            assign btn_rise[gi] = settle & btn_pressed[gi];
        end
    endgenerate

    logic confirm_rise, clear_rise, confirm_level;
    assign confirm_rise  = btn_rise[0];
    assign clear_rise    = btn_rise[1];
    assign confirm_level = g_deb[0].level_q;

    logic [2:0] sw_line, sw_col;
    logic       in_range, coord_ok;
    assign sw_line  = hh2_s2_q[5:3];
    assign sw_col   = hh2_s2_q[2:0];
    assign in_range = ({1'b0, sw_line} < LINES_L) && ({1'b0, sw_col} < COLS_L);

    state_t     state_q;
    logic       valid_q, clr_pulse_q, err_q;
    logic [2:0] line_q, col_q;
    logic [1:0] mode_q;

`ifdef SHOT_HISTORY_EN
    localparam int CELLS = N_LINES * N_COLS;
    localparam int IDX_W = $clog2(CELLS);

    logic [CELLS-1:0] hist_q;
    logic [IDX_W-1:0] sw_idx, cmd_idx;

    assign sw_idx   = IDX_W'(sw_line) * IDX_W'(N_COLS) + IDX_W'(sw_col);
    assign cmd_idx  = IDX_W'(line_q) * IDX_W'(N_COLS) + IDX_W'(col_q);
    assign coord_ok = in_range && !((hh1_s2_q == 2'b10) && hist_q[sw_idx]);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            hist_q <= '0;
        end else if (clear_rise) begin
            hist_q <= '0;
        end else if ((state_q == PRESENT) && cmd_ready && (mode_q == 2'b10)) begin
            hist_q[cmd_idx] <= 1'b1;
        end
    end
`else
    assign coord_ok = in_range;
`endif

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q     <= IDLE;
            valid_q     <= 1'b0;
            clr_pulse_q <= 1'b0;
            err_q       <= 1'b0;
            line_q      <= '0;
            col_q       <= '0;
            mode_q      <= '0;
        end else begin
            clr_pulse_q <= clear_rise;
            err_q       <= 1'b0;
            case (state_q)
                IDLE: begin
                    // A clear edge swallows a simultaneous confirm edge
                    if (clear_rise) begin
                        if (confirm_rise) state_q <= WAIT_REL;
                    end else if (confirm_rise) begin
                        line_q <= sw_line;
                        col_q  <= sw_col;
                        mode_q <= hh1_s2_q;
                        if (coord_ok) begin
                            valid_q <= 1'b1;
                            state_q <= PRESENT;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= WAIT_REL;
                        end
                    end
                end
                PRESENT: begin
                    if (clear_rise || cmd_ready) begin
                        valid_q <= 1'b0;
                        state_q <= confirm_level ? WAIT_REL : IDLE;
                    end
                end
                WAIT_REL: begin
                    if (!confirm_level) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_valid = valid_q;
    assign cmd_line  = line_q;
    assign cmd_col   = col_q;
    assign cmd_mode  = mode_q;
    assign clr_pulse = clr_pulse_q;
    assign err_coord = err_q;
    assign fsm_state = state_q;
endmodule

// File: tb/tb_modulo_entrada_jogada.sv
// Bench for modulo_entrada_jogada with DEB_CYCLES=4: a cycle model built from sample histories plus
// directed scenarios (bounce, handshake, range, clear priority, shot history) with literal expectations.
module tb_modulo_entrada_jogada;
    localparam int DEB = 4;
    localparam int NL  = 7;
    localparam int NC  = 5;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic [1:0] hh1 = 2'b00;
    logic [5:0] hh2 = 6'b000000;
    logic       button_clk = 1'b1;
    logic       button_clr = 1'b1;
    logic       cmd_ready  = 1'b0;
    logic       cmd_valid;
    logic [2:0] cmd_line, cmd_col;
    logic [1:0] cmd_mode;
    logic       clr_pulse, err_coord;
    logic [1:0] fsm_state;

    modulo_entrada_jogada #(
        .DEB_CYCLES(DEB),
        .DEB_W     (3),
        .N_LINES   (NL),
        .N_COLS    (NC)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .hh1       (hh1),
        .hh2       (hh2),
        .button_clk(button_clk),
        .button_clr(button_clr),
        .cmd_ready (cmd_ready),
        .cmd_valid (cmd_valid),
        .cmd_line  (cmd_line),
        .cmd_col   (cmd_col),
        .cmd_mode  (cmd_mode),
        .clr_pulse (clr_pulse),
        .err_coord (err_coord),
        .fsm_state (fsm_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int valid_rises = 0, err_pulses = 0, clr_pulses = 0, handshakes = 0;
    logic run_cmp = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model ----------------
    logic [9:0] raw_hist[$];   // raw samples {hh1, hh2, button_clr, button_clk}, oldest first
    logic [1:0] lvl_hist[$];   // past synced pressed levels {clear, confirm}, oldest first
    logic       m_deb_c, m_deb_r, m_busy, m_lock, e_clr_pulse, e_err;
    logic [2:0] e_line, e_col;
    logic [1:0] e_mode;
    logic       m_hist[NL*NC];

    // A new level is accepted once the current and the previous DEB-1 synced samples all disagree with it
    function automatic logic settles(input logic now_lvl, input logic acc, input int b);
        if (now_lvl == acc) return 1'b0;
        foreach (lvl_hist[k]) if (lvl_hist[k][b] == acc) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        raw_hist = {};
        lvl_hist = {};
        repeat (2) raw_hist.push_back(10'b00_000000_11);
        repeat (DEB - 1) lvl_hist.push_back(2'b00);
        m_deb_c = 0; m_deb_r = 0; m_busy = 0; m_lock = 0;
        e_clr_pulse = 0; e_err = 0; e_line = 0; e_col = 0; e_mode = 0;
        foreach (m_hist[k]) m_hist[k] = 1'b0;
    endtask

    task automatic model_step();
        logic [9:0] s;
        logic pc, pr, fc, fr, rc, rr, bad;
        s  = raw_hist[0];
        pc = ~s[0];
        pr = ~s[1];
        fc = settles(pc, m_deb_c, 0);
        fr = settles(pr, m_deb_r, 1);
        rc = fc & pc;
        rr = fr & pr;
        e_clr_pulse = rr;
        e_err = 1'b0;
        if (m_busy) begin
            if (rr || cmd_ready) begin
`ifdef SHOT_HISTORY_EN
                if (!rr && e_mode == 2'b10) m_hist[e_line * NC + e_col] = 1'b1;
`endif
                m_busy = 1'b0;
                m_lock = m_deb_c;
            end
        end else if (m_lock) begin
            if (!m_deb_c) m_lock = 1'b0;
        end else if (rr) begin
            m_lock = rc;
        end else if (rc) begin
            e_line = s[7:5];
            e_col  = s[4:2];
            e_mode = s[9:8];
            bad = (e_line >= NL) || (e_col >= NC);
`ifdef SHOT_HISTORY_EN
            if (!bad && e_mode == 2'b10 && m_hist[e_line * NC + e_col]) bad = 1'b1;
`endif
            if (bad) begin
                e_err  = 1'b1;
                m_lock = 1'b1;
            end else begin
                m_busy = 1'b1;
            end
        end
        if (rr) foreach (m_hist[k]) m_hist[k] = 1'b0;
        if (fc) m_deb_c = pc;
        if (fr) m_deb_r = pr;
        lvl_hist.push_back({pr, pc});
        void'(lvl_hist.pop_front());
        raw_hist.push_back({hh1, hh2, button_clr, button_clk});
        void'(raw_hist.pop_front());
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge clr);
            if (clr) model_reset();
            else model_step();
        end
    end

    // ---------------- per-cycle compare and transaction log ----------------
    initial begin
        logic prev_valid;
        int   exp_state;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (run_cmp && !clr) begin
                exp_state = m_busy ? 1 : (m_lock ? 2 : 0);
                chk("cmp_valid", cmd_valid, m_busy);
                chk("cmp_clr_pulse", clr_pulse, e_clr_pulse);
                chk("cmp_err_coord", err_coord, e_err);
                chk("cmp_fsm_state", fsm_state, exp_state);
                chk("cmp_line", cmd_line, e_line);
                chk("cmp_col", cmd_col, e_col);
                chk("cmp_mode", cmd_mode, e_mode);
                if (cmd_valid && !prev_valid) valid_rises++;
                if (cmd_valid && cmd_ready) begin
                    handshakes++;
                    $display("handshake line=%0d col=%0d mode=%0d", cmd_line, cmd_col, cmd_mode);
                end
                if (err_coord) begin
                    err_pulses++;
                    $display("err_coord line=%0d col=%0d", cmd_line, cmd_col);
                end
                if (clr_pulse) begin
                    clr_pulses++;
                    $display("clr_pulse state=%0d", fsm_state);
                end
                prev_valid = cmd_valid;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        #1 clr = 1'b1;
        tick(3);
        chk("reset_valid", cmd_valid, 0);
        chk("reset_clr_pulse", clr_pulse, 0);
        chk("reset_err", err_coord, 0);
        chk("reset_state", fsm_state, 0);
        clr = 1'b0;
        run_cmp = 1'b1;
        tick(5);

        // Bounce: 2-cycle chatter never settles, final press does
        hh1 = 2'b01;
        hh2 = 6'b010_011;
        for (int i = 0; i < 10; i++) begin
            button_clk = i[0];
            tick(2);
        end
        button_clk = 1'b0;
        tick(12);
        chk("bounce_rises", valid_rises, 1);
        chk("bounce_line", cmd_line, 2);
        chk("bounce_col", cmd_col, 3);

        // Handshake: fields stay put while waiting, switches ignored
        tick(4);
        hh2 = 6'b101_100;
        tick(6);
        chk("hold_valid", cmd_valid, 1);
        chk("hold_line", cmd_line, 2);
        chk("hold_col", cmd_col, 3);
        cmd_ready = 1'b1;
        tick(1);
        cmd_ready = 1'b0;
        chk("hs_valid_drop", cmd_valid, 0);
        chk("hs_count", handshakes, 1);
        chk("hs_wait_rel", fsm_state, 2);
        tick(10);
        chk("held_no_repeat", valid_rises, 1);
        button_clk = 1'b1;
        tick(10);
        chk("release_idle", fsm_state, 0);

        // Range errors
        hh2 = 6'b111_000;
        button_clk = 1'b0;
        tick(10);
        chk("line7_err", err_pulses, 1);
        chk("line7_no_cmd", valid_rises, 1);
        button_clk = 1'b1;
        tick(10);
        hh2 = 6'b000_101;
        button_clk = 1'b0;
        tick(10);
        chk("col5_err", err_pulses, 2);
        chk("col5_no_cmd", valid_rises, 1);
        button_clk = 1'b1;
        tick(10);

        // Simultaneous confirm and clear: clear wins
        hh2 = 6'b001_001;
        button_clk = 1'b0;
        button_clr = 1'b0;
        tick(10);
        chk("both_clr_pulse", clr_pulses, 1);
        chk("both_no_cmd", valid_rises, 1);
        chk("both_no_err", err_pulses, 2);
        chk("both_wait_rel", fsm_state, 2);
        button_clk = 1'b1;
        button_clr = 1'b1;
        tick(10);

        // Clear during PRESENT withdraws the command
        button_clk = 1'b0;
        tick(10);
        chk("pres_valid", cmd_valid, 1);
        chk("pres_rises", valid_rises, 2);
        button_clr = 1'b0;
        tick(10);
        chk("clr_drop_valid", cmd_valid, 0);
        chk("clr_no_hs", handshakes, 1);
        chk("clr_pulses2", clr_pulses, 2);
        button_clk = 1'b1;
        button_clr = 1'b1;
        tick(10);

        // Attack mode at (1,1), then the same cell again
        hh1 = 2'b10;
        button_clk = 1'b0;
        tick(10);
        chk("atk_rises", valid_rises, 3);
        cmd_ready = 1'b1;
        tick(1);
        cmd_ready = 1'b0;
        chk("atk_hs", handshakes, 2);
        button_clk = 1'b1;
        tick(10);
        button_clk = 1'b0;
        tick(10);
`ifdef SHOT_HISTORY_EN
        chk("repeat_err", err_pulses, 3);
        chk("repeat_no_cmd", valid_rises, 3);
`else
        chk("repeat_cmd", valid_rises, 4);
        cmd_ready = 1'b1;
        tick(1);
        cmd_ready = 1'b0;
`endif
        button_clk = 1'b1;
        tick(10);
        button_clr = 1'b0;
        tick(10);
        button_clr = 1'b1;
        tick(10);
        chk("hist_clr_pulses", clr_pulses, 3);
        button_clk = 1'b0;
        tick(10);
        chk("after_clear_valid", cmd_valid, 1);
`ifdef SHOT_HISTORY_EN
        chk("after_clear_rises", valid_rises, 4);
`else
        chk("after_clear_rises", valid_rises, 5);
`endif

        // Asynchronous reset in the middle of PRESENT
        #2 clr = 1'b1;
        #1;
        chk("async_valid", cmd_valid, 0);
        chk("async_clr_pulse", clr_pulse, 0);
        chk("async_err", err_coord, 0);
        chk("async_state", fsm_state, 0);
        run_cmp = 1'b0;
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
